// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: single transfers, byte/half/word lanes, programmable wait states.
// Define AHB_SRAM_ERR_EN to build the two-cycle ERROR response for misaligned or oversize transfers.
module ahb_sram_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                             input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = m[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [3:0]      cnt_p1, cnt_nxt;
  logic            wr_pend_p1;
  logic [AW-1:0]   wr_idx_p1;
  logic [3:0]      wr_mask_p1;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx_p0;
  logic [3:0]      mask_p0;
  logic            take_p0;
  logic            addr_err_p0;
  logic            commit;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word_p0;
  logic            unused_addr;

  // Address phase: decode the offered transfer
  assign idx_p0  = HADDR[AW+1:2];
  assign mask_p0 = lane_mask(HSIZE, HADDR[1:0]);
  assign take_p0 = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign unused_addr = ^{HADDR[31:AW+2], HTRANS[0]};

`ifdef AHB_SRAM_ERR_EN
  assign addr_err_p0 = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                       (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
`else
  assign addr_err_p0 = 1'b0;
`endif

  // Data phase: a pending write commits on the last (ready) cycle; reads forward it per lane
  assign commit     = wr_pend_p1 && (state == S_IDLE);
  assign wr_word    = lane_merge(mem[wr_idx_p1], HWDATA, wr_mask_p1);
  assign rd_word_p0 = (commit && wr_idx_p1 == idx_p0) ? wr_word : mem[idx_p0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p1;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_p1 == 4'd0) state_nxt = S_IDLE;
        else                cnt_nxt   = cnt_p1 - 4'd1;
      end
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
`endif
      default: begin
`ifdef AHB_SRAM_ERR_EN
        HRESP = (state == S_ERR2);
`endif
        state_nxt = S_IDLE;
        if (take_p0) begin
`ifdef AHB_SRAM_ERR_EN
          if (addr_err_p0) state_nxt = S_ERR1;
          else
`endif
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt_p1     <= 4'd0;
      wr_pend_p1 <= 1'b0;
      HRDATA     <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt_p1 <= cnt_nxt;
      if (take_p0)     wr_pend_p1 <= HWRITE & ~addr_err_p0;
      else if (commit) wr_pend_p1 <= 1'b0;
      if (take_p0 && !HWRITE && !addr_err_p0) HRDATA <= rd_word_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (take_p0) begin
      wr_idx_p1  <= idx_p0;
      wr_mask_p1 <= mask_p0;
    end
    if (commit) mem[wr_idx_p1] <= wr_word;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance and one three-wait instance on a shared bus.
module tb_ahb_sram_slave;
  logic        clk;
  logic        reset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;

  int          errors;
  int          checks;
  logic [31:0] xrd;
  int          xwaits;

  ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout0),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout1),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'd0;
    hsize  = 3'd0;
  endtask

  task automatic addr_phase(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel0  = (d == 0);
    hsel1  = (d == 1);
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  // Single non-pipelined transfer; leaves the bench at the negedge of the final data-phase cycle.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd);
    @(posedge clk); #1;
    addr_phase(d, a, wr, sz);
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    xwaits = 0;
    @(negedge clk);
    while (((d == 0) ? hreadyout0 : hreadyout1) == 1'b0 && xwaits < 50) begin
      xwaits++;
      @(negedge clk);
    end
    xrd = (d == 0) ? hrdata0 : hrdata1;
  endtask

  task automatic test_reset();
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b expected 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_resp0: got %b expected 0", hresp0); end
    checks++; if (hrdata0 !== 32'd0) begin errors++; $display("FAIL rst_rdata0: got %h expected 00000000", hrdata0); end
    checks++; if (hreadyout1 !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b expected 1", hreadyout1); end
    checks++; if (hresp1 !== 1'b0) begin errors++; $display("FAIL rst_resp1: got %b expected 0", hresp1); end
    checks++; if (hrdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata1: got %h expected 00000000", hrdata1); end
  endtask

  task automatic test_forward();
    @(posedge clk); #1;
    addr_phase(0, 32'h10, 1'b1, 3'd2);
    @(posedge clk); #1;
    addr_phase(0, 32'h10, 1'b0, 3'd2);
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL fwd_wr_ready: got %b expected 1", hreadyout0); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL fwd_rd_ready: got %b expected 1", hreadyout0); end
    checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_rdata: got %h expected deadbeef", hrdata0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int j = 0; j <= 8; j++) begin
      @(posedge clk); #1;
      if (j < 4)      addr_phase(0, 32'h40 + 32'(4 * j), 1'b1, 3'd2);
      else if (j < 8) addr_phase(0, 32'h4C - 32'(4 * (j - 4)), 1'b0, 3'd2);
      else            bus_idle();
      if (j >= 1 && j <= 4) hwdata = 32'hC0DE0000 | 32'(j - 1);
      @(negedge clk);
      checks++;
      if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", j, hreadyout0); end
      if (j >= 5) begin
        exp = 32'hC0DE0000 | 32'(3 - (j - 5));
        checks++;
        if (hrdata0 !== exp) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", j, hrdata0, exp); end
      end
    end
  endtask

  task automatic test_byte_lanes();
    xfer(0, 32'h20, 1'b1, 3'd2, 32'h11223344);
    xfer(0, 32'h21, 1'b1, 3'd0, 32'hFFFFAAFF);
    xfer(0, 32'h20, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'h1122AA44) begin errors++; $display("FAIL byte_write: got %h expected 1122aa44", xrd); end
    checks++; if (xwaits !== 0) begin errors++; $display("FAIL byte_waits: got %0d expected 0", xwaits); end
    xfer(0, 32'h22, 1'b1, 3'd1, 32'h5566FFFF);
    xfer(0, 32'h23, 1'b0, 3'd0, 32'h0);
    checks++; if (xrd !== 32'h5566AA44) begin errors++; $display("FAIL half_write: got %h expected 5566aa44", xrd); end
  endtask

  task automatic test_wait_states();
    xfer(1, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D);
    checks++; if (xwaits !== 3) begin errors++; $display("FAIL ws_write_waits: got %0d expected 3", xwaits); end
    xfer(1, 32'h34, 1'b1, 3'd2, 32'h0BADF00D);
    xfer(1, 32'h30, 1'b0, 3'd2, 32'h0);
    checks++; if (xwaits !== 3) begin errors++; $display("FAIL ws_read_waits: got %0d expected 3", xwaits); end
    checks++; if (xrd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rdata: got %h expected cafef00d", xrd); end
    checks++; if (hresp1 !== 1'b0) begin errors++; $display("FAIL ws_resp: got %b expected 0", hresp1); end
    // A write to 0x30 is offered throughout the wait cycles of a read of 0x34 and must be ignored.
    @(posedge clk); #1;
    addr_phase(1, 32'h34, 1'b0, 3'd2);
    @(posedge clk); #1;
    addr_phase(1, 32'h30, 1'b1, 3'd2);
    hwdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (hreadyout1 !== 1'b0) begin errors++; $display("FAIL ws_low[%0d]: got %b expected 0", k, hreadyout1); end
      @(posedge clk); #1;
    end
    bus_idle();
    @(negedge clk);
    checks++; if (hreadyout1 !== 1'b1) begin errors++; $display("FAIL ws_high: got %b expected 1", hreadyout1); end
    checks++; if (hrdata1 !== 32'h0BADF00D) begin errors++; $display("FAIL ws_rdata2: got %h expected 0badf00d", hrdata1); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (hreadyout1 !== 1'b1) begin errors++; $display("FAIL ws_no_accept[%0d]: got %b expected 1", k, hreadyout1); end
    end
    xfer(1, 32'h30, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_ignored_write: got %h expected cafef00d", xrd); end
  endtask

  task automatic test_misaligned();
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h01020304);
    @(posedge clk); #1;
    addr_phase(0, 32'h13, 1'b1, 3'd2);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hA5A5A5A5;
    @(negedge clk);
`ifdef AHB_SRAM_ERR_EN
    checks++; if (hreadyout0 !== 1'b0) begin errors++; $display("FAIL err1_ready: got %b expected 0", hreadyout0); end
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err1_resp: got %b expected 1", hresp0); end
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL err2_ready: got %b expected 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err2_resp: got %b expected 1", hresp0); end
    @(negedge clk);
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL err_done_resp: got %b expected 0", hresp0); end
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'h01020304) begin errors++; $display("FAIL err_mem: got %h expected 01020304", xrd); end
`else
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b expected 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL mis_resp: got %b expected 0", hresp0); end
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'hA5A5A5A5) begin errors++; $display("FAIL mis_aligned_write: got %h expected a5a5a5a5", xrd); end
`endif
  endtask

  task automatic test_wrap_busy();
    xfer(0, 32'h400, 1'b1, 3'd2, 32'h600DCAFE);
    xfer(0, 32'h000, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'h600DCAFE) begin errors++; $display("FAIL wrap_rdata: got %h expected 600dcafe", xrd); end
    @(posedge clk); #1;
    addr_phase(0, 32'h000, 1'b1, 3'd2);
    htrans = 2'b01;
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL busy_ready: got %b expected 1", hreadyout0); end
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin
      errors++; $display("FAIL busy_okay: got ready=%b resp=%b expected ready=1 resp=0", hreadyout0, hresp0);
    end
    xfer(0, 32'h000, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'h600DCAFE) begin errors++; $display("FAIL busy_no_write: got %h expected 600dcafe", xrd); end
  endtask

  task automatic test_reset_mid_wait();
    xfer(1, 32'h0C, 1'b1, 3'd2, 32'h33333333);
    xfer(1, 32'h0C, 1'b0, 3'd2, 32'h0);
    @(posedge clk); #1;
    addr_phase(1, 32'h0C, 1'b1, 3'd2);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hFFFFFFFF;
    checks++; if (hreadyout1 !== 1'b0) begin errors++; $display("FAIL rmw_in_wait: got %b expected 0", hreadyout1); end
    #2 reset = 1'b0;
    #1;
    checks++; if (hreadyout1 !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b expected 1", hreadyout1); end
    checks++; if (hresp1 !== 1'b0) begin errors++; $display("FAIL rmw_resp: got %b expected 0", hresp1); end
    checks++; if (hrdata1 !== 32'd0) begin errors++; $display("FAIL rmw_rdata: got %h expected 00000000", hrdata1); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    xfer(1, 32'h0C, 1'b0, 3'd2, 32'h0);
    checks++; if (xrd !== 32'h33333333) begin errors++; $display("FAIL rmw_discard: got %h expected 33333333", xrd); end
    checks++; if (xwaits !== 3) begin errors++; $display("FAIL rmw_waits: got %0d expected 3", xwaits); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    xrd    = 32'd0;
    xwaits = 0;
    bus_idle();
    hwdata = 32'd0;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_forward();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_misaligned();
    test_wrap_busy();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) for the multicycle ARM core's AHB initiator; holds a word-organised on-chip SRAM.
- Accepts single transfers from the bus. Supports byte, halfword and word reads/writes.
- Inserts a programmable number of wait states per data phase.
- Sits behind the address decoder and drives HRDATA/HREADYOUT/HRESP back through the bus mux.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- HSEL  input  1  slave select from the decoder.
- HADDR  input  32  byte address.
- HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-level ready; the address phase is accepted only when high.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending-write flag 0. SRAM contents are not reset.
- Reset mid-transfer aborts the data phase; any uncommitted write is discarded.
- Transfer acceptance:
  - A transfer is accepted at a rising edge when HSEL & HTRANS[1] & HREADY.
  - The block then registers HADDR, HWRITE and HSIZE for the data phase.
  - IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY response with no side effects.
- Word index is HADDR[log2(DEPTH)+1:2]. Addresses beyond DEPTH wrap (upper bits ignored).
- Byte lanes (little-endian):
  - size 0: lane HADDR[1:0].
  - size 1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - size 2: all four lanes.
- States:
  - IDLE: no data phase pending, HREADYOUT=1.
    - Accept + WAIT_STATES>0 -> WAIT.
    - Accept + error condition -> ERR1.
    - Accept otherwise -> stays IDLE; the data phase completes in the next cycle.
  - WAIT: HREADYOUT=0; the counter loads WAIT_STATES-1 and decrements. At 0 -> IDLE, and HREADYOUT=1 in the following cycle.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE.
    - A new transfer accepted in this cycle (HREADY=1) is processed normally.
- Writes:
  - Write data is sampled from HWDATA in the final data-phase cycle (HREADYOUT=1) and committed to the SRAM at that edge.
  - Only the selected lanes are written.
- Reads:
  - HRDATA is the full 32-bit word at the registered index, valid when HREADYOUT=1. The master selects lanes.
  - HRDATA holds its last value outside read data phases.
- Latency: read data or write commit occurs WAIT_STATES+1 cycles after address-phase acceptance.
- Read-after-write hazard: a read whose address phase coincides with the committing write's data phase to the same word must return the merged new data. Per-lane forwarding is required; there is no extra wait.
- Back-to-back pipelined transfers at 0 wait states sustain one transfer per cycle.
- A transfer offered while HREADYOUT=0 is not accepted, because HREADY is low.

Optional Feature:
- Macro AHB_SRAM_ERR_EN.
- Defined:
  - Error conditions are: a misaligned access (size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]≠0), or HSIZE>2.
  - Any error condition produces the two-cycle ERR1/ERR2 response with no SRAM write. HRDATA is unchanged.
- Undefined:
  - ERR states are not built and HRESP is tied to 0.
  - Misaligned addresses are aligned down to the size boundary.
  - HSIZE>2 is treated as a word access.

Test Plan:
- Reset with reset=0 mid-WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the pending write to word 3 leaves word 3 unchanged.
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF in the read's data phase (forwarding path); 1 transfer/cycle.
- Byte write 0xAA to 0x21 over word 0x11223344 -> read 0x20 returns 0x1122AA44. Halfword 0x5566 to 0x22 -> 0x5566AA44.
- WAIT_STATES=3: read -> HREADYOUT low exactly 3 cycles, then high with data. An address offered during the wait is ignored until HREADY=1.
- AHB_SRAM_ERR_EN defined, word write to 0x13 -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1); memory unchanged. Undefined -> OKAY, write lands at 0x10.
- DEPTH=256: write 0x400 -> read 0x000 returns the same data (wrap). HTRANS=BUSY with HSEL=1 -> OKAY, no write.
